// File: rtl/mem_arb_pkg.sv
// Shared state encoding, default widths and grant indices for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned BUSY_W     = 16;

  // Bit positions in the two-requester one-hot grant vector.
  localparam int unsigned GNT_I_BIT  = 0;
  localparam int unsigned GNT_D_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention, grants the requester that did not win last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_d_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i[GNT_D_BIT] && (!req_i[GNT_I_BIT] || !last_d_i)) begin
      gnt_o[GNT_D_BIT] = 1'b1;
    end else if (req_i[GNT_I_BIT]) begin
      gnt_o[GNT_I_BIT] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache reads and D-cache reads/write-backs onto one memory port,
// round-robin on contention, with a saturating count of port-occupied cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [BUSY_W-1:0] busy_cycles
);

  localparam logic [BUSY_W-1:0] BUSY_MAX = '1;

  arb_state_e        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BUSY_W-1:0] busy_q, busy_d;
  logic [1:0]        req;
  logic [1:0]        gnt;

  assign req[GNT_I_BIT] = ic_read;
  assign req[GNT_D_BIT] = dc_read | dc_write;

  rr_pick2 u_rr_pick2 (
    .req_i    (req),
    .last_d_i (last_d_q),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    ic_ready    = 1'b0;
    dc_ready    = 1'b0;
    ic_rdata    = '0;
    dc_rdata    = '0;

    if ((state_q != ST_IDLE) && (busy_q != BUSY_MAX)) begin
      busy_d = busy_q + BUSY_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // A simultaneous read and write-back from the D-cache is serviced as the write.
        if (gnt[GNT_D_BIT]) begin
          state_d     = ST_GNT_D;
          last_d_d    = 1'b1;
          mem_write_d = dc_write;
          mem_read_d  = ~dc_write;
          mem_addr_d  = dc_addr;
          mem_wdata_d = dc_wdata;
        end else if (gnt[GNT_I_BIT]) begin
          state_d     = ST_GNT_I;
          last_d_d    = 1'b0;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = ic_addr;
          mem_wdata_d = '0;
        end
      end
      ST_GNT_I: begin
        if (mem_ready) begin
          ic_ready    = 1'b1;
          ic_rdata    = mem_rdata;
          state_d     = ST_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      ST_GNT_D: begin
        if (mem_ready) begin
          dc_ready    = 1'b1;
          dc_rdata    = mem_rdata;
          state_d     = ST_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy_cycles = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_read;
  logic [27:0]  ic_addr;
  logic [127:0] ic_rdata;
  logic         ic_ready;
  logic         dc_read;
  logic         dc_write;
  logic [27:0]  dc_addr;
  logic [127:0] dc_wdata;
  logic [127:0] dc_rdata;
  logic         dc_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [15:0]  busy_cycles;

  int total = 0;
  int bad   = 0;

  // Model state: who won the previous grant, and total occupied cycles since reset.
  bit m_last_d;
  int m_busy;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .ic_read     (ic_read),
    .ic_addr     (ic_addr),
    .ic_rdata    (ic_rdata),
    .ic_ready    (ic_ready),
    .dc_read     (dc_read),
    .dc_write    (dc_write),
    .dc_addr     (dc_addr),
    .dc_wdata    (dc_wdata),
    .dc_rdata    (dc_rdata),
    .dc_ready    (dc_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .busy_cycles (busy_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".mem_read"}, mem_read, 1'b0);
    chk({tag, ".mem_write"}, mem_write, 1'b0);
    chk({tag, ".ic_ready"}, ic_ready, 1'b0);
    chk({tag, ".dc_ready"}, dc_ready, 1'b0);
    chk({tag, ".ic_rdata"}, ic_rdata, 128'd0);
    chk({tag, ".dc_rdata"}, dc_rdata, 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle_outputs("rst");
    chk("rst.mem_addr", mem_addr, 128'd0);
    chk("rst.mem_wdata", mem_wdata, 128'd0);
    chk("rst.busy", busy_cycles, 128'd0);
    @(negedge clk);
    rst      = 1'b1;
    m_last_d = 1'b0;
    m_busy   = 0;
  endtask

  // Called just after a negedge with the FSM idle and requests applied.
  // lat = number of granted cycles; memory answers in the last one.
  task automatic txn(input int lat, input bit withdraw, input bit drop, input logic [127:0] rd);
    bit          i_req, d_req, wd, wr, fin;
    logic [27:0] e_addr;
    logic [127:0] e_wdata;
    i_req   = ic_read;
    d_req   = dc_read | dc_write;
    wd      = d_req && (!i_req || !m_last_d);
    wr      = wd && dc_write;
    e_addr  = wd ? dc_addr : ic_addr;
    e_wdata = dc_wdata;
    @(posedge clk);
    @(negedge clk);
    if (withdraw) begin
      if (wd) begin dc_read = 1'b0; dc_write = 1'b0; end
      else ic_read = 1'b0;
    end
    for (int k = 1; k <= lat; k++) begin
      fin = (k == lat);
      if (fin) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      #1;
      chk("gnt.mem_read", mem_read, !wr);
      chk("gnt.mem_write", mem_write, wr);
      chk("gnt.mem_addr", mem_addr, e_addr);
      if (wr) chk("gnt.mem_wdata", mem_wdata, e_wdata);
      chk("gnt.ic_ready", ic_ready, !wd && fin);
      chk("gnt.dc_ready", dc_ready, wd && fin);
      chk("gnt.ic_rdata", ic_rdata, (!wd && fin) ? rd : 128'd0);
      chk("gnt.dc_rdata", dc_rdata, (wd && fin) ? rd : 128'd0);
      if (!fin) @(negedge clk);
    end
    @(posedge clk);
    m_busy   = (m_busy + lat > 65535) ? 65535 : m_busy + lat;
    m_last_d = wd;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (drop) begin
      if (wd) begin dc_read = 1'b0; dc_write = 1'b0; end
      else ic_read = 1'b0;
    end
    #1;
    chk_idle_outputs("post");
    chk("post.busy", busy_cycles, 128'(m_busy));
  endtask

  initial begin
    rst = 1'b0; ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    m_last_d = 1'b0; m_busy = 0;

    // Reset values, then first grant on the first edge after release: D write beats I read.
    do_reset();
    ic_read = 1'b1; dc_write = 1'b1;
    ic_addr = 28'h0123456; dc_addr = 28'h0abcdef; dc_wdata = rand128();
    txn(2, 1'b0, 1'b1, rand128());
    txn(3, 1'b0, 1'b1, rand128());

    // Lone I-cache read with 3-cycle memory latency.
    do_reset();
    ic_read = 1'b1; ic_addr = 28'h0000040;
    txn(3, 1'b0, 1'b1, 128'hDEAD0000_00000000_00000000_0000BEEF);

    // Both held continuously: grants alternate starting with D.
    ic_read = 1'b1; dc_read = 1'b1;
    ic_addr = 28'h1111111; dc_addr = 28'h2222222;
    for (int t = 0; t < 6; t++) txn(1 + (t % 3), 1'b0, 1'b0, rand128());
    ic_read = 1'b0; dc_read = 1'b0;

    // Read and write together from the D-cache: only the write goes out.
    dc_read = 1'b1; dc_write = 1'b1; dc_addr = 28'h0555555; dc_wdata = rand128();
    txn(2, 1'b0, 1'b1, rand128());

    // mem_ready while idle is ignored.
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = rand128();
    #1;
    chk_idle_outputs("idle_rdy");
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    chk_idle_outputs("idle_rdy2");
    chk("idle_rdy.busy", busy_cycles, 128'(m_busy));

    // Request withdrawn mid-grant still completes.
    ic_read = 1'b1; ic_addr = 28'h0777777;
    txn(3, 1'b1, 1'b1, rand128());

    // Randomized traffic.
    for (int t = 0; t < 25; t++) begin
      int sel;
      sel = int'($urandom_range(1, 3));
      ic_read  = sel[0];
      dc_write = sel[1] ? 1'($urandom_range(0, 1)) : 1'b0;
      dc_read  = sel[1] ? (!dc_write || 1'($urandom_range(0, 1))) : 1'b0;
      ic_addr  = 28'($urandom()); dc_addr = 28'($urandom()); dc_wdata = rand128();
      txn(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b1, rand128());
      ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
    end

    // Reset during a D grant with mem_ready pending: no dc_ready, everything cleared.
    dc_read = 1'b1; dc_addr = 28'h0999999;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_mid.mem_read_pre", mem_read, 1'b1);
    mem_ready = 1'b1; mem_rdata = rand128();
    rst = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    chk("rst_mid.mem_addr", mem_addr, 128'd0);
    chk("rst_mid.busy", busy_cycles, 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("rst_mid2");
    dc_read = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    rst = 1'b1; m_last_d = 1'b0; m_busy = 0;

    // Saturation: preset to FFFE, 5-cycle transaction ends at FFFF.
    @(negedge clk);
    force dut.busy_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.busy_q;
    #1;
    chk("sat.preset", busy_cycles, 128'h0FFFE);
    m_busy = 65534;
    ic_read = 1'b1; ic_addr = 28'h0000080;
    txn(5, 1'b0, 1'b1, rand128());
    chk("sat.final", busy_cycles, 128'h0FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
